prs_tx_feeder: RTL and testbench

//  Upstream data source for the SPI slave TX path. Generates pseudo-random (PRS) words with a Galois LFSR.

---
 rtl/prs_tx_feeder_if.sv | 27 ++
 rtl/prs_tx_feeder.sv | 109 ++++++++++
 tb/tb_prs_tx_feeder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/prs_tx_feeder_if.sv
// TX handshake between the PRS word feeder and the SPI slave.
// master = feeder side, slave = SPI slave side.
interface prs_tx_feeder_if #(
  parameter int DATA_BITS = 16
);
  logic                 i_TX_req;
  logic                 i_busy;
  logic [DATA_BITS-1:0] o_TX_buff;
  logic                 o_TX_valid;
  logic                 o_ready;

  modport master (
    input  i_TX_req,
    input  i_busy,
    output o_TX_buff,
    output o_TX_valid,
    output o_ready
  );

  modport slave (
    output i_TX_req,
    output i_busy,
    input  o_TX_buff,
    input  o_TX_valid,
    input  o_ready
  );
endinterface

// File: rtl/prs_tx_feeder.sv
// Galois-LFSR word source for the SPI slave TX path, one word per frame.
// Optional PRS_FRAME_TAG_EN puts the frame count in the top bits of each word.
module prs_tx_feeder #(
  parameter int                   DATA_BITS = 16,
  parameter logic [DATA_BITS-1:0] POLY      = 16'hB400,
  parameter logic [DATA_BITS-1:0] SEED      = 16'hACE1,
  parameter int                   CNT_BITS  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  prs_tx_feeder_if.master     bus,
  output logic [CNT_BITS-1:0] o_frame_cnt
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [DATA_BITS-1:0] SEED_L =
    (SEED == '0) ? DATA_BITS'(1) : SEED;

  typedef enum logic [1:0] {
    GEN   = 2'd0,
    READY = 2'd1,
    SENT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] lfsr_q, lfsr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] buff_q, buff_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic                 fb;
  logic [DATA_BITS-1:0] lfsr_step;
  logic [DATA_BITS-1:0] shift_step;
  logic [DATA_BITS-1:0] load_word;

  always_comb begin
    fb         = lfsr_q[0];
    lfsr_step  = (lfsr_q >> 1) ^ (fb ? POLY : '0);
    shift_step = {shift_q[DATA_BITS-2:0], fb};
`ifdef PRS_FRAME_TAG_EN
    load_word  = {cnt_q, shift_step[DATA_BITS-CNT_BITS-1:0]};
`else
    load_word  = shift_step;
`endif
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    shift_d   = shift_q;
    buff_d    = buff_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      GEN: begin
        if (i_en) begin
          lfsr_d  = lfsr_step;
          shift_d = shift_step;
          if (bit_cnt_q == LAST) begin
            bit_cnt_d = '0;
            buff_d    = load_word;
            state_d   = READY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      // busy wins over a dropped request: the slave already latched the word
      READY: begin
        if (bus.i_busy) state_d = SENT;
      end
      SENT: begin
        if (!bus.i_busy) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = GEN;
        end
      end
      default: state_d = GEN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= GEN;
      lfsr_q    <= SEED_L;
      shift_q   <= '0;
      buff_q    <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      shift_q   <= shift_d;
      buff_q    <= buff_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.o_TX_buff  = buff_q;
  assign bus.o_ready    = (state_q == READY);
  assign bus.o_TX_valid = (state_q == READY) & bus.i_TX_req;
  assign o_frame_cnt    = cnt_q;

endmodule

// File: tb/tb_prs_tx_feeder.sv
// Directed bench for prs_tx_feeder with a bit-level LFSR reference.
// Handles both the plain and the PRS_FRAME_TAG_EN build.
module tb_prs_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] w0, w1, w2, wx;
  int          n;

  prs_tx_feeder_if #(.DATA_BITS(16)) bus ();

  prs_tx_feeder #(
    .DATA_BITS(16),
    .POLY(16'hB400),
    .SEED(16'hACE1),
    .CNT_BITS(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .bus(bus),
    .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_word(output logic [15:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = m_lfsr[0];
      m_lfsr = (m_lfsr >> 1) ^ (b ? 16'hB400 : 16'h0000);
      w = {w[14:0], b};
    end
  endtask

  function automatic logic [15:0] tagw(input logic [15:0] w,
                                       input logic [7:0] c);
`ifdef PRS_FRAME_TAG_EN
    return {c, w[7:0]};
`else
    return w + 16'(c) * 16'h0;
`endif
  endfunction

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.o_ready !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
    if (cyc >= 64) chk("ready_timeout", 32'(cyc), 32'd16);
  endtask

  task automatic frame();
    bus.i_TX_req = 1'b1;
    tick();
    bus.i_busy = 1'b1;
    tick();
    bus.i_busy   = 1'b0;
    bus.i_TX_req = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b1;
    bus.i_TX_req = 1'b0;
    bus.i_busy   = 1'b0;
    m_lfsr       = 16'hACE1;
    #2;
    chk("rst_buff", 32'(bus.o_TX_buff), 32'h0);
    chk("rst_valid", 32'(bus.o_TX_valid), 32'h0);
    chk("rst_ready", 32'(bus.o_ready), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);

    // test 1: first word exactly 16 clocks after release
    do_reset();
    model_word(w0);
    model_word(w1);
    model_word(w2);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("t1_ready_early", 32'(bus.o_ready), 32'h0);
    end
    chk("t1_ready", 32'(bus.o_ready), 32'h1);
    chk("t1_buff", 32'(bus.o_TX_buff), 32'(tagw(w0, 8'h00)));
    chk("t1_valid", 32'(bus.o_TX_valid), 32'h0);

    // test 2: served frame
    bus.i_TX_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_valid", 32'(bus.o_TX_valid), 32'h1);
      tick();
    end
    bus.i_busy = 1'b1;
    tick();
    chk("t2_sent_valid", 32'(bus.o_TX_valid), 32'h0);
    chk("t2_sent_ready", 32'(bus.o_ready), 32'h0);
    for (int i = 1; i < 40; i++) tick();
    chk("t2_sent_buff", 32'(bus.o_TX_buff), 32'(tagw(w0, 8'h00)));
    chk("t2_cnt_hold", 32'(frame_cnt), 32'h0);
    bus.i_busy   = 1'b0;
    bus.i_TX_req = 1'b0;
    tick();
    chk("t2_cnt", 32'(frame_cnt), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) chk("t2_gen_buff", 32'(bus.o_TX_buff), 32'(tagw(w0, 8'h00)));
      if (i == 15) chk("t2_ready_early", 32'(bus.o_ready), 32'h0);
    end
    chk("t2_ready", 32'(bus.o_ready), 32'h1);
    chk("t2_buff", 32'(bus.o_TX_buff), 32'(tagw(w1, 8'h01)));

    // test 3: aborted request re-serves the same word
    bus.i_TX_req = 1'b1;
    tick();
    bus.i_TX_req = 1'b0;
    tick();
    tick();
    chk("t3_abort_ready", 32'(bus.o_ready), 32'h1);
    chk("t3_abort_buff", 32'(bus.o_TX_buff), 32'(tagw(w1, 8'h01)));
    chk("t3_abort_cnt", 32'(frame_cnt), 32'h1);
    bus.i_TX_req = 1'b1;
    tick();
    bus.i_busy   = 1'b1;
    bus.i_TX_req = 1'b0;
    tick();
    chk("t3_sent_buff", 32'(bus.o_TX_buff), 32'(tagw(w1, 8'h01)));
    chk("t3_sent_ready", 32'(bus.o_ready), 32'h0);
    bus.i_busy = 1'b0;
    tick();
    chk("t3_cnt", 32'(frame_cnt), 32'h2);
    wait_ready(n);
    chk("t3_lat", 32'(n), 32'd16);
    chk("t3_buff", 32'(bus.o_TX_buff), 32'(tagw(w2, 8'h02)));

    // test 4: stall generation at bit 5 for 10 clocks
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      en = (i > 5 && i <= 15) ? 1'b0 : 1'b1;
      tick();
      if (i == 25) chk("t4_ready_early", 32'(bus.o_ready), 32'h0);
    end
    en = 1'b1;
    chk("t4_ready", 32'(bus.o_ready), 32'h1);
    chk("t4_buff", 32'(bus.o_TX_buff), 32'(tagw(w0, 8'h00)));

    // test 5: 257 frames, counter wraps and sequence follows the model
    model_word(wx);
    for (int i = 1; i <= 257; i++) begin
      frame();
      chk("t5_cnt", 32'(frame_cnt), 32'(i % 256));
      wait_ready(n);
      model_word(wx);
      chk("t5_buff", 32'(bus.o_TX_buff), 32'(tagw(wx, 8'(i))));
    end
    chk("t5_cnt_final", 32'(frame_cnt), 32'h1);

    // test 6: reset in SENT, then tag check at frame count 5
    bus.i_TX_req = 1'b1;
    tick();
    bus.i_busy = 1'b1;
    tick();
    chk("t6_in_sent", 32'(bus.o_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_buff", 32'(bus.o_TX_buff), 32'h0);
    chk("t6_rst_valid", 32'(bus.o_TX_valid), 32'h0);
    chk("t6_rst_cnt", 32'(frame_cnt), 32'h0);
    bus.i_busy   = 1'b0;
    bus.i_TX_req = 1'b0;
    tick();
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
    for (int i = 1; i <= 16; i++) tick();
    chk("t6_ready", 32'(bus.o_ready), 32'h1);
    model_word(wx);
    chk("t6_buff", 32'(bus.o_TX_buff), 32'(tagw(w0, 8'h00)));
    for (int i = 1; i <= 5; i++) begin
      frame();
      wait_ready(n);
      model_word(wx);
    end
    chk("t6_cnt5", 32'(frame_cnt), 32'h5);
`ifdef PRS_FRAME_TAG_EN
    chk("t6_tag", 32'(bus.o_TX_buff[15:8]), 32'h05);
`endif
    chk("t6_buff5", 32'(bus.o_TX_buff), 32'(tagw(wx, 8'h05)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
